// File: rtl/simon_core_arbiter_pkg.sv
// Shared types and defaults for the SIMON core arbiter: FSM state encoding,
// core handshake bundle and the key re-expansion decision.
package simon_core_arbiter_pkg;

  localparam int SIMON_N = 64;
  localparam int SIMON_M = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_KEY_REQ,
    S_KEY_WAIT,
    S_DATA_REQ,
    S_DATA_WAIT,
    S_ERR,
    S_RESP
  } arb_state_t;

  // One core handshake lane: "load" means the core can take a new pulse,
  // "done" means it has finished the work that pulse started.
  typedef struct packed {
    logic load;
    logic done;
  } core_hs_t;

  function automatic logic needs_rekey(input logic key_vld, input logic owner_match,
                                       input logic force_rekey);
    return !key_vld || !owner_match || force_rekey;
  endfunction

endpackage

// File: rtl/simon_core_arbiter_if.sv
// Client request/response channel plus core handshake bundled for the arbiter.
// master = arbiter side, slave = clients and core.
interface simon_core_arbiter_if
  import simon_core_arbiter_pkg::*;
#(
  parameter int N  = SIMON_N,
  parameter int M  = SIMON_M,
  parameter int NC = 2
);
  logic [NC-1:0]                  req_valid;
  logic [NC-1:0]                  req_ready;
  logic [NC-1:0]                  req_enc_dec;
  logic [NC-1:0]                  req_rekey;
  logic [NC-1:0][1:0][N-1:0]      req_block;
  logic [NC-1:0][M-1:0][N-1:0]    req_key;
  logic [NC-1:0]                  resp_valid;
  logic [NC-1:0]                  resp_ready;
  logic [1:0][N-1:0]              resp_data;
  logic                           resp_err;
  logic                           core_newKey;
  logic                           core_newData;
  logic                           core_readData;
  logic                           core_enc_dec;
  logic [1:0][N-1:0]              core_BLOCK;
  logic [M-1:0][N-1:0]            core_KEY;
  logic                           core_loadKey;
  logic                           core_loadData;
  logic                           core_doneKey;
  logic                           core_doneData;
  logic [1:0][N-1:0]              core_outData;

  modport master (
    input  req_valid, req_enc_dec, req_rekey, req_block, req_key, resp_ready,
           core_loadKey, core_loadData, core_doneKey, core_doneData, core_outData,
    output req_ready, resp_valid, resp_data, resp_err,
           core_newKey, core_newData, core_readData, core_enc_dec, core_BLOCK, core_KEY
  );

  modport slave (
    output req_valid, req_enc_dec, req_rekey, req_block, req_key, resp_ready,
           core_loadKey, core_loadData, core_doneKey, core_doneData, core_outData,
    input  req_ready, resp_valid, resp_data, resp_err,
           core_newKey, core_newData, core_readData, core_enc_dec, core_BLOCK, core_KEY
  );

endinterface

// File: rtl/simon_core_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module simon_rr_arbiter #(
  parameter int NC = 2,
  parameter int IW = 1
) (
  input  logic [NC-1:0] req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [NC-1:0] grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NC; k++) begin
      cand = IW'((int'(ptr_i) + k) % NC);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simon_core_arbiter.sv
// Shares one SIMON core between NC clients: round-robin grant, key reuse across
// same-owner requests, core handshake sequencing with watchdog, per-client response.
module simon_core_arbiter
  import simon_core_arbiter_pkg::*;
#(
  parameter int N  = SIMON_N,
  parameter int M  = SIMON_M,
  parameter int NC = 2,
  parameter int WD = 255,
  parameter int WB = 8
) (
  input logic                  clk,
  input logic                  R,
  simon_core_arbiter_if.master bus
);

  localparam int IW = (NC > 2) ? 2 : 1;

  arb_state_t          state_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [IW-1:0]       rr_ptr_d;
  logic [IW-1:0]       g_q;
  logic [IW-1:0]       key_own_q;
  logic                key_vld_q;
  logic [WB-1:0]       wd_q;
  logic [NC-1:0]       resp_valid_q;
  logic                resp_err_q;
  logic [1:0][N-1:0]   resp_data_q;
  logic                new_key_q;
  logic                new_data_q;
  logic                read_data_q;
  logic                enc_dec_q;
  logic [1:0][N-1:0]   block_q;
  logic [M-1:0][N-1:0] key_q;

  logic [NC-1:0]       grant;
  logic [IW-1:0]       gidx;
  logic                gany;
  logic [NC-1:0]       g_onehot;
  core_hs_t            key_hs;
  core_hs_t            data_hs;

  simon_rr_arbiter #(.NC(NC), .IW(IW)) u_rr (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (gidx),
    .any_o   (gany)
  );

  assign rr_ptr_d     = IW'((int'(gidx) + 1) % NC);
  assign g_onehot     = NC'(1) << g_q;
  assign key_hs.load  = bus.core_loadKey;
  assign key_hs.done  = bus.core_doneKey;
  assign data_hs.load = bus.core_loadData;
  assign data_hs.done = bus.core_doneData;

  always_ff @(posedge clk) begin
    if (R) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      g_q          <= '0;
      key_own_q    <= '0;
      key_vld_q    <= 1'b0;
      wd_q         <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      new_key_q    <= 1'b0;
      new_data_q   <= 1'b0;
      read_data_q  <= 1'b0;
      enc_dec_q    <= 1'b0;
      block_q      <= '0;
      key_q        <= '0;
    end else begin
      new_key_q   <= 1'b0;
      new_data_q  <= 1'b0;
      read_data_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|bus.req_valid) state_q <= S_ARB;
        end
        // Requester may have dropped valid since IDLE; fall back if nobody is left.
        S_ARB: begin
          if (gany) begin
            g_q       <= gidx;
            rr_ptr_q  <= rr_ptr_d;
            block_q   <= bus.req_block[gidx];
            key_q     <= bus.req_key[gidx];
            enc_dec_q <= bus.req_enc_dec[gidx];
            if (needs_rekey(key_vld_q, key_own_q == gidx, bus.req_rekey[gidx]))
              state_q <= S_KEY_REQ;
            else
              state_q <= S_DATA_REQ;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_KEY_REQ: begin
          if (key_hs.load) begin
            new_key_q <= 1'b1;
            wd_q      <= WB'(WD);
            key_vld_q <= 1'b0;
            state_q   <= S_KEY_WAIT;
          end
        end
        S_KEY_WAIT: begin
          if (key_hs.done) begin
            key_vld_q <= 1'b1;
            key_own_q <= g_q;
            state_q   <= S_DATA_REQ;
          end else if (wd_q == '0) begin
            state_q <= S_ERR;
          end else begin
            wd_q <= wd_q - 1'b1;
          end
        end
        S_DATA_REQ: begin
          if (data_hs.load) begin
            new_data_q <= 1'b1;
            wd_q       <= WB'(WD);
            state_q    <= S_DATA_WAIT;
          end
        end
        S_DATA_WAIT: begin
          if (data_hs.done) begin
            resp_data_q  <= bus.core_outData;
            read_data_q  <= 1'b1;
            resp_valid_q <= g_onehot;
            state_q      <= S_RESP;
          end else if (wd_q == '0) begin
            state_q <= S_ERR;
          end else begin
            wd_q <= wd_q - 1'b1;
          end
        end
        // Core state is unknown after a timeout, so the expanded key is discarded.
        S_ERR: begin
          key_vld_q    <= 1'b0;
          resp_err_q   <= 1'b1;
          resp_data_q  <= '0;
          resp_valid_q <= g_onehot;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          enc_dec_q <= 1'b0;
          if (bus.resp_ready[g_q]) begin
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = (state_q == S_ARB) ? grant : '0;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.core_newKey   = new_key_q;
  assign bus.core_newData  = new_data_q;
  assign bus.core_readData = read_data_q;
  assign bus.core_enc_dec  = enc_dec_q;
  assign bus.core_BLOCK    = block_q;
  assign bus.core_KEY      = key_q;

endmodule

// File: tb/tb_simon_core_arbiter.sv
// Directed bench for simon_core_arbiter with a behavioural core stub whose result
// depends on the key captured at the last newKey pulse.
module tb_simon_core_arbiter;
  localparam int N  = 64;
  localparam int M  = 2;
  localparam int NC = 2;
  localparam int WD = 255;
  localparam int WB = 8;

  localparam logic [1:0][N-1:0] B_A = {64'h1000, 64'h1};
  localparam logic [1:0][N-1:0] B_B = {64'h5000, 64'hF0};
  localparam logic [1:0][N-1:0] B_C = {64'h2, 64'h3};
  localparam logic [M-1:0][N-1:0] K0 = {64'h10, 64'h20};
  localparam logic [M-1:0][N-1:0] K1 = {64'h300, 64'h400};
  // Hand-computed stub results: enc {b1+k0, b0^k1}, dec {b1-k0, b0^k1^FF}
  localparam logic [1:0][N-1:0] R_A_K0_ENC = {64'h1020, 64'h11};
  localparam logic [1:0][N-1:0] R_B_K0_DEC = {64'h4FE0, 64'h1F};
  localparam logic [1:0][N-1:0] R_C_K1_ENC = {64'h402, 64'h303};
  localparam logic [1:0][N-1:0] R_C_K1_DEC = {64'hFFFF_FFFF_FFFF_FC02, 64'h3FC};

  logic clk = 1'b0;
  logic R   = 1'b1;
  always #5 clk = ~clk;

  simon_core_arbiter_if #(.N(N), .M(M), .NC(NC)) bus ();

  simon_core_arbiter #(.N(N), .M(M), .NC(NC), .WD(WD), .WB(WB)) dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int nk_cnt = 0;
  int nd_cnt = 0;
  int rd_cnt = 0;
  int ktmr   = 0;
  int dtmr   = 0;
  logic withhold = 1'b0;
  logic [M-1:0][N-1:0] kreg = '0;

  // Core stub: key expansion 3 cycles, block 4 cycles after the pulse.
  always @(posedge clk) begin
    if (bus.core_newKey)   nk_cnt <= nk_cnt + 1;
    if (bus.core_newData)  nd_cnt <= nd_cnt + 1;
    if (bus.core_readData) rd_cnt <= rd_cnt + 1;
    if (R) begin
      ktmr <= 0;
      dtmr <= 0;
      bus.core_doneKey  <= 1'b0;
      bus.core_doneData <= 1'b0;
      bus.core_outData  <= '0;
    end else begin
      bus.core_doneKey  <= 1'b0;
      bus.core_doneData <= 1'b0;
      if (bus.core_newKey) begin
        kreg <= bus.core_KEY;
        ktmr <= 3;
      end else if (ktmr != 0) begin
        ktmr <= ktmr - 1;
        if (ktmr == 1) bus.core_doneKey <= 1'b1;
      end
      if (bus.core_newData) dtmr <= 4;
      else if (withhold) dtmr <= 0;
      else if (dtmr != 0) begin
        dtmr <= dtmr - 1;
        if (dtmr == 1) begin
          bus.core_doneData <= 1'b1;
          bus.core_outData  <= bus.core_enc_dec ?
            {bus.core_BLOCK[1] + kreg[0], bus.core_BLOCK[0] ^ kreg[1]} :
            {bus.core_BLOCK[1] - kreg[0], bus.core_BLOCK[0] ^ kreg[1] ^ 64'hFF};
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic setup(input int c, input logic enc, input logic rk,
                       input logic [1:0][N-1:0] blk, input logic [M-1:0][N-1:0] key);
    bus.req_enc_dec[c] = enc;
    bus.req_rekey[c]   = rk;
    bus.req_block[c]   = blk;
    bus.req_key[c]     = key;
  endtask

  task automatic issue(input int c, input logic enc, input logic rk,
                       input logic [1:0][N-1:0] blk, input logic [M-1:0][N-1:0] key,
                       output bit ok);
    setup(c, enc, rk, blk, key);
    bus.req_valid[c] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.req_ready[c]) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    bus.req_valid[c] = 1'b0;
    bus.req_rekey[c] = 1'b0;
  endtask

  task automatic wait_grant(output int idx, output bit ok);
    ok  = 1'b0;
    idx = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (|bus.req_ready) begin
        idx = bus.req_ready[1] ? 1 : 0;
        ok  = 1'b1;
        break;
      end
    end
    @(negedge clk);
    if (ok) begin
      bus.req_valid[idx] = 1'b0;
      bus.req_rekey[idx] = 1'b0;
    end
  endtask

  task automatic wait_valid(input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (bus.resp_valid[c]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic ack(input int c);
    bus.resp_ready[c] = 1'b1;
    @(negedge clk);
    bus.resp_ready[c] = 1'b0;
  endtask

  task automatic test_reset();
    R = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.core_newKey, bus.core_newData,
         bus.core_readData, bus.core_enc_dec} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0", {bus.req_ready, bus.resp_valid, bus.resp_err,
               bus.core_newKey, bus.core_newData, bus.core_readData, bus.core_enc_dec});
    end
    checks++;
    if ({bus.resp_data, bus.core_BLOCK, bus.core_KEY} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {bus.resp_data, bus.core_BLOCK, bus.core_KEY});
    end
    R = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first();
    bit ok_g, ok_v;
    int nk0 = nk_cnt, nd0 = nd_cnt, rd0 = rd_cnt;
    issue(0, 1'b1, 1'b0, B_A, K0, ok_g);
    checks++;
    if (!ok_g) begin errors++; $display("FAIL first_grant got 0 want 1"); end
    wait_valid(0, ok_v);
    checks++;
    if (!ok_v) begin errors++; $display("FAIL first_resp_valid got 0 want 1"); end
    checks++;
    if (bus.resp_data !== R_A_K0_ENC) begin
      errors++; $display("FAIL first_data got %h want %h", bus.resp_data, R_A_K0_ENC);
    end
    checks++;
    if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL first_err got %b want 0", bus.resp_err); end
    ack(0);
    checks++;
    if (nk_cnt - nk0 != 1) begin errors++; $display("FAIL first_newKey got %0d want 1", nk_cnt - nk0); end
    checks++;
    if (nd_cnt - nd0 != 1) begin errors++; $display("FAIL first_newData got %0d want 1", nd_cnt - nd0); end
    checks++;
    if (rd_cnt - rd0 != 1) begin errors++; $display("FAIL first_readData got %0d want 1", rd_cnt - rd0); end
  endtask

  task automatic test_key_reuse();
    bit ok_g, ok_v;
    int nk0 = nk_cnt, nd0 = nd_cnt;
    issue(0, 1'b0, 1'b0, B_B, K0, ok_g);
    wait_valid(0, ok_v);
    checks++;
    if (!ok_g || !ok_v || bus.resp_data !== R_B_K0_DEC) begin
      errors++; $display("FAIL reuse_data got %h want %h", bus.resp_data, R_B_K0_DEC);
    end
    ack(0);
    checks++;
    if (nk_cnt - nk0 != 0) begin errors++; $display("FAIL reuse_newKey got %0d want 0", nk_cnt - nk0); end
    checks++;
    if (nd_cnt - nd0 != 1) begin errors++; $display("FAIL reuse_newData got %0d want 1", nd_cnt - nd0); end
    nk0 = nk_cnt;
    issue(0, 1'b1, 1'b1, B_A, K0, ok_g);
    wait_valid(0, ok_v);
    checks++;
    if (!ok_v || bus.resp_data !== R_A_K0_ENC) begin
      errors++; $display("FAIL rekey_data got %h want %h", bus.resp_data, R_A_K0_ENC);
    end
    ack(0);
    checks++;
    if (nk_cnt - nk0 != 1) begin errors++; $display("FAIL rekey_newKey got %0d want 1", nk_cnt - nk0); end
  endtask

  task automatic test_round_robin();
    bit ok_g, ok_v;
    int idx, nk0;
    logic [1:0][N-1:0] exp_rr [2][2];
    exp_rr[0][0] = R_A_K0_ENC;
    exp_rr[0][1] = R_C_K1_ENC;
    exp_rr[1][0] = R_B_K0_DEC;
    exp_rr[1][1] = R_C_K1_DEC;
    R = 1'b1;
    repeat (2) @(negedge clk);
    R = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin
        setup(0, 1'b1, 1'b0, B_A, K0);
        setup(1, 1'b1, 1'b0, B_C, K1);
      end else begin
        setup(0, 1'b0, 1'b0, B_B, K0);
        setup(1, 1'b0, 1'b0, B_C, K1);
      end
      bus.req_valid = 2'b11;
      for (int k = 0; k < 2; k++) begin
        nk0 = nk_cnt;
        wait_grant(idx, ok_g);
        checks++;
        if (!ok_g || idx != k) begin
          errors++; $display("FAIL rr_order round %0d got %0d want %0d", r, idx, k);
        end
        if (!ok_g) begin
          bus.req_valid = '0;
          return;
        end
        wait_valid(idx, ok_v);
        checks++;
        if (!ok_v || bus.resp_data !== exp_rr[r][k]) begin
          errors++; $display("FAIL rr_data round %0d got %h want %h", r, bus.resp_data, exp_rr[r][k]);
        end
        ack(idx);
        checks++;
        if (nk_cnt - nk0 != 1) begin
          errors++; $display("FAIL rr_newKey round %0d got %0d want 1", r, nk_cnt - nk0);
        end
      end
    end
  endtask

  task automatic test_watchdog();
    bit ok_g, ok_v, seen;
    int cnt, nk0;
    withhold = 1'b1;
    issue(1, 1'b1, 1'b0, B_C, K1, ok_g);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.core_newData) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cnt++;
      if (bus.resp_valid[1]) break;
    end
    checks++;
    if (!ok_g || !seen || cnt != WD + 2) begin
      errors++; $display("FAIL wd_latency got %0d want %0d", cnt, WD + 2);
    end
    checks++;
    if (bus.resp_valid !== 2'b10 || bus.resp_err !== 1'b1) begin
      errors++; $display("FAIL wd_err got valid %b err %b want valid 10 err 1", bus.resp_valid, bus.resp_err);
    end
    checks++;
    if (bus.resp_data !== '0) begin errors++; $display("FAIL wd_data got %h want 0", bus.resp_data); end
    ack(1);
    withhold = 1'b0;
    nk0 = nk_cnt;
    issue(1, 1'b1, 1'b0, B_C, K1, ok_g);
    wait_valid(1, ok_v);
    checks++;
    if (!ok_v || bus.resp_data !== R_C_K1_ENC || bus.resp_err !== 1'b0) begin
      errors++; $display("FAIL wd_recover_data got %h want %h", bus.resp_data, R_C_K1_ENC);
    end
    ack(1);
    checks++;
    if (nk_cnt - nk0 != 1) begin errors++; $display("FAIL wd_rekey got %0d want 1", nk_cnt - nk0); end
  endtask

  task automatic test_backpressure();
    bit ok_g, ok_v;
    int idx;
    issue(0, 1'b1, 1'b0, B_A, K0, ok_g);
    wait_valid(0, ok_v);
    setup(1, 1'b1, 1'b0, B_C, K1);
    bus.req_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 2'b01 || bus.resp_data !== R_A_K0_ENC || bus.req_ready !== 2'b00) begin
        errors++;
        $display("FAIL hold_cycle %0d got valid %b ready %b data %h want valid 01 ready 00 data %h",
                 i, bus.resp_valid, bus.req_ready, bus.resp_data, R_A_K0_ENC);
      end
    end
    ack(0);
    wait_grant(idx, ok_g);
    checks++;
    if (!ok_g || idx != 1) begin errors++; $display("FAIL hold_next_grant got %0d want 1", idx); end
    wait_valid(1, ok_v);
    checks++;
    if (!ok_v || bus.resp_data !== R_C_K1_ENC) begin
      errors++; $display("FAIL hold_next_data got %h want %h", bus.resp_data, R_C_K1_ENC);
    end
    ack(1);
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid();
    bit ok_g, ok_v, seen;
    int nk0;
    withhold = 1'b1;
    issue(0, 1'b1, 1'b0, B_A, K0, ok_g);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.core_newData) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok_g || !seen) begin errors++; $display("FAIL midreset_reach_data got %b want 1", seen); end
    R = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.core_newKey, bus.core_newData,
         bus.core_readData, bus.core_enc_dec} !== '0 ||
        {bus.resp_data, bus.core_BLOCK, bus.core_KEY} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got valid %b enc %b block %h want all 0",
               bus.resp_valid, bus.core_enc_dec, bus.core_BLOCK);
    end
    R = 1'b0;
    withhold = 1'b0;
    @(negedge clk);
    nk0 = nk_cnt;
    issue(0, 1'b1, 1'b0, B_A, K0, ok_g);
    wait_valid(0, ok_v);
    checks++;
    if (!ok_v || bus.resp_data !== R_A_K0_ENC) begin
      errors++; $display("FAIL midreset_data got %h want %h", bus.resp_data, R_A_K0_ENC);
    end
    ack(0);
    checks++;
    if (nk_cnt - nk0 != 1) begin errors++; $display("FAIL midreset_newKey got %0d want 1", nk_cnt - nk0); end
  endtask

  initial begin
    bus.req_valid     = '0;
    bus.req_enc_dec   = '0;
    bus.req_rekey     = '0;
    bus.req_block     = '0;
    bus.req_key       = '0;
    bus.resp_ready    = '0;
    bus.core_loadKey  = 1'b1;
    bus.core_loadData = 1'b1;
    test_reset();
    test_first();
    test_key_reuse();
    test_round_robin();
    test_watchdog();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
